rf_scoreboard: RTL

- Parametrised register file for the pipelined core, replacing the fixed 2-read/1-write file.
- Adds a configurable read-port count, hardwired-zero register 0, and optional write-through bypass.
- Adds a per-register pending-write scoreboard. Decode uses it for RAW stall/forward decisions.
- Sits between ID (read, issue) and WB (write, clear).

---
 rtl/rf_scoreboard.sv | 93 +++++++++
 1 files changed

// File: rtl/rf_scoreboard.sv
// Parametrised register file with a hardwired-zero r0, optional write-through
// bypass and a per-register pending-write scoreboard used for RAW/WAW decisions.
module rf_scoreboard #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2,
  parameter int BYPASS = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_RD*ADDR_W-1:0]   ra,
  output logic [NUM_RD*DATA_W-1:0]   rd,
  output logic [NUM_RD-1:0]          rd_busy,
  input  logic                       we,
  input  logic [ADDR_W-1:0]          wa,
  input  logic [DATA_W-1:0]          wd,
  input  logic                       iss_valid,
  input  logic [ADDR_W-1:0]          iss_addr,
  output logic                       iss_conflict,
  output logic [ADDR_W:0]            busy_cnt
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic BYP = (BYPASS != 0);

  logic [DATA_W-1:0] regs_r [DEPTH];
  logic [DEPTH-1:0]  busy_r;
  logic [DEPTH-1:0]  busy_nxt_s;
  logic [ADDR_W:0]   cnt_r;
  logic              wr_en_s;
  logic              iss_en_s;

  function automatic logic [ADDR_W:0] popcount(input logic [DEPTH-1:0] v);
    logic [ADDR_W:0] c;
    c = '0;
    for (int i = 0; i < DEPTH; i++) begin
      c = c + (ADDR_W+1)'(v[i]);
    end
    return c;
  endfunction

  assign wr_en_s  = we && (wa != '0);
  assign iss_en_s = iss_valid && (iss_addr != '0);

  // Next busy vector: a same-edge issue beats the writeback clear; r0 never busy.
  always_comb begin
    busy_nxt_s = '0;
    for (int i = 1; i < DEPTH; i++) begin
      busy_nxt_s[i] = (iss_en_s && (iss_addr == ADDR_W'(i))) ||
                      (busy_r[i] && !(wr_en_s && (wa == ADDR_W'(i))));
    end
  end

  // Register storage; address 0 is never written so it stays zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_r[i] <= '0;
      end
    end else if (wr_en_s) begin
      regs_r[wa] <= wd;
    end
  end

  // Scoreboard bits and their registered population count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r <= '0;
      cnt_r  <= '0;
    end else begin
      busy_r <= busy_nxt_s;
      cnt_r  <= popcount(busy_nxt_s);
    end
  end

  assign busy_cnt = cnt_r;

  // A write landing this cycle retires the producer, so with bypass the reader
  // sees the new data and no longer waits on it.
  assign iss_conflict = iss_en_s && busy_r[iss_addr] &&
                        !(BYP && we && (wa == iss_addr));

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [ADDR_W-1:0] a_s;
    logic              hit_s;
    assign a_s   = ra[p*ADDR_W +: ADDR_W];
    assign hit_s = BYP && we && (wa == a_s);
    assign rd[p*DATA_W +: DATA_W] = !rst_n ? '0 :
                                    (hit_s && (wa != '0)) ? wd : regs_r[a_s];
    assign rd_busy[p] = rst_n && busy_r[a_s] && !hit_s;
  end

endmodule
